alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Request/response sequencer in front of an ALU: single-cycle ops pass straight through,
// DIV/MOD/MUL get a start pulse and a bounded wait for their own done strobe.
module alu_sequencer #(
    parameter int TIMEOUT = 40,
    parameter int CW      = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic        alu_start,
    output logic [4:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_result,
    input  logic [15:0] alu_result_high,
    input  logic        alu_done_div,
    input  logic        alu_done_mod,
    input  logic        alu_done_mul,
    input  logic        alu_z,
    input  logic        alu_n,
    input  logic        alu_c,
    input  logic        alu_v,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [15:0] rsp_result_high,
    output logic [3:0]  rsp_flags,
    output logic        rsp_err
);

    localparam logic [4:0] OP_DIV  = 5'd2;
    localparam logic [4:0] OP_MOD  = 5'd5;
    localparam logic [4:0] OP_MUL  = 5'd7;
    localparam logic [4:0] OP_LAST = 5'd17;

    typedef enum logic [2:0] {IDLE, EXEC, START, WAIT, RESP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          hs, req_multi, req_illegal, done_match, timed_out;

    assign req_ready = (state == IDLE);
    assign alu_start = (state == START);
    assign rsp_valid = (state == RESP);

    assign hs          = req_valid && req_ready;
    assign req_multi   = (req_op == OP_DIV) || (req_op == OP_MOD) || (req_op == OP_MUL);
    assign req_illegal = (req_op > OP_LAST);
    // Only the strobe belonging to the registered op counts; the others are stray.
    assign done_match  = ((alu_op == OP_DIV) && alu_done_div) ||
                         ((alu_op == OP_MOD) && alu_done_mod) ||
                         ((alu_op == OP_MUL) && alu_done_mul);
    assign timed_out   = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (hs) begin
                    if (req_illegal)    state_nxt = RESP;
                    else if (req_multi) state_nxt = START;
                    else                state_nxt = EXEC;
                end
            end
            EXEC:    state_nxt = RESP;
            START:   state_nxt = WAIT;
            WAIT:    if (done_match || timed_out) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt             <= '0;
            alu_op          <= '0;
            alu_a           <= '0;
            alu_b           <= '0;
            rsp_result      <= '0;
            rsp_result_high <= '0;
            rsp_flags       <= '0;
            rsp_err         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        alu_op <= req_op;
                        alu_a  <= req_a;
                        alu_b  <= req_b;
                        if (req_illegal) begin
                            rsp_result      <= '0;
                            rsp_result_high <= '0;
                            rsp_flags       <= '0;
                            rsp_err         <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    rsp_result      <= alu_result;
                    rsp_result_high <= '0;
                    rsp_flags       <= {alu_z, alu_n, alu_c, alu_v};
                    rsp_err         <= 1'b0;
                end
                START: cnt <= '0;
                WAIT: begin
                    cnt <= cnt + CW'(1);
                    // A done landing on the last allowed cycle still beats the timeout.
                    if (done_match) begin
                        rsp_result      <= alu_result;
                        rsp_result_high <= (alu_op == OP_MUL) ? alu_result_high : 16'd0;
                        rsp_flags       <= {alu_z, alu_n, alu_c, alu_v};
                        rsp_err         <= 1'b0;
                    end else if (timed_out) begin
                        rsp_result      <= '0;
                        rsp_result_high <= '0;
                        rsp_flags       <= '0;
                        rsp_err         <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
